// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the frame-buffer arbiter.
package fb_pkg;
  localparam int FB_W   = 320;
  localparam int FB_H   = 240;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;
  localparam int VGA_W  = 640;
  localparam int VGA_H  = 480;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } fb_state_e;
endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO for queued camera writes. DEPTH must be a power of 2.
module fb_wr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp, rp;

  // Extra pointer bit separates full from empty when the indices match.
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  // Pointer update; push and pop in the same cycle both take effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)  wp <= wp + 1'b1;
      if (pop  && !empty) rp <= rp + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fb_arbiter.sv
// Shares the frame-buffer SPRAM between 2x-upscaled VGA scan-out reads
// and queued camera writes. Reads own every even active column; writes
// drain into all other slots. Coordinates to pixel latency is 3 cycles.
module fb_arbiter import fb_pkg::*; #(
  parameter int FB_W       = fb_pkg::FB_W,
  parameter int FB_H       = fb_pkg::FB_H,
  parameter int ADDR_W     = fb_pkg::ADDR_W,
  parameter int DATA_W     = fb_pkg::DATA_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        vga_row,
  input  logic [9:0]        vga_col,
  input  logic              vga_valid,
  input  logic              cam_wr_valid,
  output logic              cam_wr_ready,
  input  logic [ADDR_W-1:0] cam_wr_addr,
  input  logic [DATA_W-1:0] cam_wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  localparam int                STAGES    = 2;
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'((FB_H - 1) * FB_W);
  localparam logic [9:0]        LAST_COL  = 10'(VGA_W - 1);

  fb_state_e         state;
  logic [ADDR_W-1:0] line_base, base_now, rd_addr;
  logic              frame_start, running, rd_slot, push, pop, full, empty;
  wr_req_t           wr_in, wr_head;
  logic [STAGES:0]   vld_pipe;
  logic [STAGES-1:0] rd_pipe;

  // Slot decision: the origin pixel itself is already a read slot.
  assign frame_start  = (vga_row == '0) && (vga_col == '0);
  assign running      = (state == RUN) || frame_start;
  assign rd_slot      = running && vga_valid && !vga_col[0];
  assign pop          = !rd_slot && !empty;
  assign cam_wr_ready = rst_n && !full;
  assign push         = cam_wr_valid && cam_wr_ready;
  assign wr_in        = {cam_wr_addr, cam_wr_data};

  // Row 0 forces the base combinationally so the first read of a frame is
  // correct even though the register still holds the previous frame's end.
  assign base_now = (vga_row == '0) ? '0 : line_base;
  assign rd_addr  = base_now + ADDR_W'(vga_col[9:1]);

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(wr_req_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (wr_in),
    .pop   (pop),
    .dout  (wr_head),
    .full  (full),
    .empty (empty)
  );

  // Frame sync: wait for the scan origin, then stay in RUN until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           state <= WAIT_FRAME;
    else if (frame_start) state <= RUN;
  end

  // Line base steps by one framebuffer line at the end of each odd active row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      line_base <= '0;
    else if (vga_row == '0)
      line_base <= '0;
    else if (vga_valid && vga_row[0] && (vga_col == LAST_COL) && (line_base != LAST_LINE))
      line_base <= line_base + LINE_STEP;
  end

  // Memory port: read wins its slot, otherwise drain one queued write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else if (rd_slot) begin
      mem_addr  <= rd_addr;
      mem_we    <= 1'b0;
    end else if (pop) begin
      mem_addr  <= wr_head.addr;
      mem_wdata <= wr_head.data;
      mem_we    <= 1'b1;
    end else begin
      mem_we    <= 1'b0;
    end
  end

  // Valid and read-strobe pipelines aligned to the SPRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      rd_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], running && vga_valid};
      rd_pipe  <= {rd_pipe[STAGES-2:0], rd_slot};
    end
  end

  // Pixel register: capture returning read data, hold it for the odd column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   pix_data <= '0;
    else if (!vld_pipe[STAGES-1]) pix_data <= '0;
    else if (rd_pipe[STAGES-1])   pix_data <= mem_rdata;
  end

  assign pix_valid = vld_pipe[STAGES];
endmodule
